// File: rtl/pc_step_ctrl_pkg.sv
// Shared types and constants for the program-counter step controller.
// Holds the debounce state encoding and the synchroniser depth.
package pc_step_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESS_B = 2'd1,
      HELD    = 2'd2,
      REL_B   = 2'd3
   } deb_state_t;

   localparam int SYNC_STAGES = 2;

endpackage : pc_step_pkg

// File: rtl/pc_step_ctrl_if.sv
// Button/PC bundle between the environment (master) and pc_step_ctrl (slave).
// Inputs are levels sampled on clk; outputs are registered and change only after clk rises.
interface pc_step_if #(
   parameter int PC_W = 8
) ();
   import pc_step_pkg::*;

   logic            manual_plus;
   logic            pc_ld;
   logic [PC_W-1:0] pc_in;
   logic            pc_hold;
   logic [PC_W-1:0] PC;
   logic            step_pulse;
   logic            key_state;
   logic            pc_wrap;
   deb_state_t      dbg_state;

   modport master (
      output manual_plus, pc_ld, pc_in, pc_hold,
      input  PC, step_pulse, key_state, pc_wrap, dbg_state
   );

   modport slave (
      input  manual_plus, pc_ld, pc_in, pc_hold,
      output PC, step_pulse, key_state, pc_wrap, dbg_state
   );

endinterface : pc_step_if

// File: rtl/pc_step_ctrl_key_debounce.sv
// Synchronises and debounces an active-low push button, producing one step per
// confirmed press plus optional auto-repeat steps while the button stays held.
module key_debounce
   import pc_step_pkg::*;
#(
   parameter int DEB_CYC   = 10000,
   parameter int CNT_W     = 20,
   parameter int REPEAT_EN = 0,
   parameter int HOLD_CYC  = 25000000,
   parameter int REP_CYC   = 5000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_raw_n,
   output logic       step_pulse,
   output logic       key_state,
   output deb_state_t state
);

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   key_s;

   deb_state_t             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0]       rep_cnt_q, rep_cnt_d;
   logic                   rep_first_q, rep_first_d;
   logic                   key_state_q, key_state_d;
   logic                   step_q, step_d;
   logic [CNT_W-1:0]       rep_target;

   // Released level is 1, so the synchroniser resets to 1 to avoid a false press.
   assign sync_d = {sync_q[SYNC_STAGES-2:0], key_raw_n};
   assign key_s  = sync_q[SYNC_STAGES-1];

   assign rep_target = rep_first_q ? HOLD_LAST : REP_LAST;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= '1;
         state_q     <= IDLE;
         cnt_q       <= '0;
         rep_cnt_q   <= '0;
         rep_first_q <= 1'b1;
         key_state_q <= 1'b1;
         step_q      <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rep_cnt_q   <= rep_cnt_d;
         rep_first_q <= rep_first_d;
         key_state_q <= key_state_d;
         step_q      <= step_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rep_cnt_d   = rep_cnt_q;
      rep_first_d = rep_first_q;
      key_state_d = key_state_q;
      step_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (!key_s) begin
               state_d = PRESS_B;
               cnt_d   = '0;
            end
         end

         PRESS_B: begin
            if (key_s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d     = HELD;
               cnt_d       = '0;
               key_state_d = 1'b0;
               step_d      = 1'b1;
               rep_cnt_d   = '0;
               rep_first_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         HELD: begin
            if (key_s) begin
               state_d = REL_B;
               cnt_d   = '0;
            end else if (REPEAT_EN != 0) begin
               // First repeat waits HOLD_CYC, later ones REP_CYC.
               if (rep_cnt_q == rep_target) begin
                  step_d      = 1'b1;
                  rep_cnt_d   = '0;
                  rep_first_d = 1'b0;
               end else begin
                  rep_cnt_d = rep_cnt_q + 1'b1;
               end
            end
         end

         REL_B: begin
            if (!key_s) begin
               state_d     = HELD;
               cnt_d       = '0;
               rep_cnt_d   = '0;
               rep_first_d = 1'b1;
            end else if (cnt_q == DEB_LAST) begin
               state_d     = IDLE;
               cnt_d       = '0;
               key_state_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d     = IDLE;
            cnt_d       = '0;
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
            key_state_d = 1'b1;
         end
      endcase
   end

   assign step_pulse = step_q;
   assign key_state  = key_state_q;
   assign state      = state_q;

endmodule : key_debounce

// File: rtl/pc_step_ctrl.sv
// Program-counter step controller: debounced button steps drive a PC register
// with synchronous load (highest priority), freeze and wrap at PC_LAST.
module pc_step_ctrl
   import pc_step_pkg::*;
#(
   parameter int              PC_W      = 8,
   parameter int              DEB_CYC   = 10000,
   parameter int              CNT_W     = 20,
   parameter int              REPEAT_EN = 0,
   parameter int              HOLD_CYC  = 25000000,
   parameter int              REP_CYC   = 5000000,
   parameter logic [PC_W-1:0] PC_LAST   = {PC_W{1'b1}}
) (
   input  logic     clk,
   input  logic     pc_clr,
   pc_step_if.slave bus
);

   logic [PC_W-1:0] pc_q, pc_d;
   logic            wrap_q, wrap_d;
   logic            step;
   logic            key_state;
   deb_state_t      deb_state;

   key_debounce #(
      .DEB_CYC   (DEB_CYC),
      .CNT_W     (CNT_W),
      .REPEAT_EN (REPEAT_EN),
      .HOLD_CYC  (HOLD_CYC),
      .REP_CYC   (REP_CYC)
   ) u_key_debounce (
      .clk        (clk),
      .rst_n      (pc_clr),
      .key_raw_n  (bus.manual_plus),
      .step_pulse (step),
      .key_state  (key_state),
      .state      (deb_state)
   );

   always_ff @(posedge clk or negedge pc_clr) begin
      if (!pc_clr) begin
         pc_q   <= '0;
         wrap_q <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         wrap_q <= wrap_d;
      end
   end

   // A step coinciding with load or hold is dropped, never queued.
   always_comb begin
      pc_d   = pc_q;
      wrap_d = 1'b0;
      if (bus.pc_ld) begin
         pc_d = bus.pc_in;
      end else if (!bus.pc_hold && step) begin
         if (pc_q == PC_LAST) begin
            pc_d   = '0;
            wrap_d = 1'b1;
         end else begin
            pc_d = pc_q + 1'b1;
         end
      end
   end

   assign bus.PC         = pc_q;
   assign bus.step_pulse = step;
   assign bus.key_state  = key_state;
   assign bus.pc_wrap    = wrap_q;
   assign bus.dbg_state  = deb_state;

endmodule : pc_step_ctrl

// File: tb/tb_pc_step_ctrl.sv
// Bench for pc_step_ctrl: two instances (no repeat with PC_LAST=5, repeat with
// full-range PC) share one stimulus stream and are compared every cycle to a model.
module tb_pc_step_ctrl;
   import pc_step_pkg::*;

   localparam int         PC_W     = 8;
   localparam int         DEB_CYC  = 4;
   localparam int         CNT_W    = 8;
   localparam int         HOLD_CYC = 8;
   localparam int         REP_CYC  = 3;
   localparam logic [7:0] LAST0    = 8'd5;
   localparam logic [7:0] LAST1    = 8'hFF;

   // clock / reset
   logic clk    = 1'b0;
   logic pc_clr = 1'b0;
   always #5 clk = ~clk;

   logic       raw  = 1'b1;
   logic       ld   = 1'b0;
   logic       hold = 1'b0;
   logic [7:0] pin  = 8'd0;

   int n_checks = 0;
   int n_err    = 0;

   pc_step_if #(.PC_W(PC_W)) if0 ();
   pc_step_if #(.PC_W(PC_W)) if1 ();

   assign if0.manual_plus = raw;
   assign if0.pc_ld       = ld;
   assign if0.pc_in       = pin;
   assign if0.pc_hold     = hold;
   assign if1.manual_plus = raw;
   assign if1.pc_ld       = ld;
   assign if1.pc_in       = pin;
   assign if1.pc_hold     = hold;

   pc_step_ctrl #(
      .PC_W(PC_W), .DEB_CYC(DEB_CYC), .CNT_W(CNT_W), .REPEAT_EN(0),
      .HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC), .PC_LAST(LAST0)
   ) dut0 (.clk(clk), .pc_clr(pc_clr), .bus(if0));

   pc_step_ctrl #(
      .PC_W(PC_W), .DEB_CYC(DEB_CYC), .CNT_W(CNT_W), .REPEAT_EN(1),
      .HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC), .PC_LAST(LAST1)
   ) dut1 (.clk(clk), .pc_clr(pc_clr), .bus(if1));

   // reference model: the button is a delayed level; a level change is accepted
   // after DEB_CYC+1 consecutive samples of the new level
   logic [7:0] m_pc[2];
   logic       m_step[2];
   logic       m_wrap[2];
   logic       m_s1, m_s2, m_deb, m_dis;
   int         m_run, m_age;

   function automatic logic [7:0] last_of(input int d);
      return (d == 0) ? LAST0 : LAST1;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_pc[d]   = 8'd0;
         m_step[d] = 1'b0;
         m_wrap[d] = 1'b0;
      end
      m_s1  = 1'b1;
      m_s2  = 1'b1;
      m_deb = 1'b1;
      m_dis = 1'b0;
      m_run = 0;
      m_age = 0;
   endtask

   // advance the model across one rising edge using the inputs now applied
   task automatic model_tick();
      logic ns0, ns1, ks;
      if (!pc_clr) begin
         model_reset();
      end else begin
         for (int d = 0; d < 2; d++) begin
            m_wrap[d] = 1'b0;
            if (ld) m_pc[d] = pin;
            else if (!hold && m_step[d]) begin
               if (m_pc[d] == last_of(d)) begin
                  m_pc[d]   = 8'd0;
                  m_wrap[d] = 1'b1;
               end else begin
                  m_pc[d] = m_pc[d] + 8'd1;
               end
            end
         end
         ns0 = 1'b0;
         ns1 = 1'b0;
         ks  = m_s2;
         if (ks != m_deb) begin
            m_run++;
            if (m_run == DEB_CYC + 1) begin
               m_deb = ks;
               m_run = 0;
               if (ks == 1'b0) begin
                  ns0   = 1'b1;
                  ns1   = 1'b1;
                  m_age = 0;
                  m_dis = 1'b0;
               end
            end else if (m_deb == 1'b0) begin
               m_dis = 1'b1;
            end
         end else begin
            m_run = 0;
            if (m_deb == 1'b0) begin
               if (m_dis) begin
                  m_dis = 1'b0;
                  m_age = 0;
               end else begin
                  m_age++;
                  if (m_age >= HOLD_CYC && ((m_age - HOLD_CYC) % REP_CYC) == 0) ns1 = 1'b1;
               end
            end
         end
         m_step[0] = ns0;
         m_step[1] = ns1;
         m_s2 = m_s1;
         m_s1 = raw;
      end
   endtask

   // scoreboard
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("pc0",   32'(if0.PC),         32'(m_pc[0]));
      chk("step0", 32'(if0.step_pulse), 32'(m_step[0]));
      chk("key0",  32'(if0.key_state),  32'(m_deb));
      chk("wrap0", 32'(if0.pc_wrap),    32'(m_wrap[0]));
      chk("pc1",   32'(if1.PC),         32'(m_pc[1]));
      chk("step1", 32'(if1.step_pulse), 32'(m_step[1]));
      chk("key1",  32'(if1.key_state),  32'(m_deb));
      chk("wrap1", 32'(if1.pc_wrap),    32'(m_wrap[1]));
   endtask

   // driver
   task automatic step();
      model_tick();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic press(input int low_cyc, input int high_cyc);
      raw = 1'b0;
      for (int i = 0; i < low_cyc; i++) step();
      raw = 1'b1;
      for (int i = 0; i < high_cyc; i++) step();
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_pc"},   32'(if0.PC),         32'd0);
      chk({tag, "_step"}, 32'(if0.step_pulse), 32'd0);
      chk({tag, "_key"},  32'(if0.key_state),  32'd1);
      chk({tag, "_wrap"}, 32'(if0.pc_wrap),    32'd0);
      chk({tag, "_st"},   32'(if0.dbg_state),  32'(IDLE));
      chk({tag, "_pc1"},  32'(if1.PC),         32'd0);
   endtask

   initial begin
      int first_pulse, key_back, cnt0, cnt1, wraps, found, seg;
      model_reset();

      // reset
      step();
      step();
      chk_reset_values("rst");
      pc_clr = 1'b1;
      for (int i = 0; i < 3; i++) step();

      // clean press: pulse after E6, release confirmed after release + 6
      first_pulse = -1;
      key_back    = -1;
      cnt0        = 0;
      raw = 1'b0;
      for (int e = 0; e < 32; e++) begin
         if (e == 20) raw = 1'b1;
         step();
         if (if0.step_pulse) begin
            cnt0++;
            if (first_pulse < 0) first_pulse = e;
         end
         if (e >= 20 && if0.key_state && key_back < 0) key_back = e;
      end
      chk("press_latency", 32'(first_pulse), 32'(DEB_CYC + 2));
      chk("press_count",   32'(cnt0), 32'd1);
      chk("press_pc",      32'(if0.PC), 32'd1);
      chk("release_latency", 32'(key_back), 32'(20 + DEB_CYC + 2));

      // bounce never stable long enough
      for (int r = 0; r < 5; r++) begin
         raw = 1'b0;
         step();
         step();
         raw = 1'b1;
         step();
      end
      for (int i = 0; i < 10; i++) step();
      chk("bounce_pc",    32'(if0.PC), 32'd1);
      chk("bounce_state", 32'(if0.dbg_state), 32'(IDLE));

      // long hold: repeat instance pulses at E6,14,17,20,23,26,29
      cnt0 = 0;
      cnt1 = 0;
      raw = 1'b0;
      for (int e = 0; e < 42; e++) begin
         if (e == 30) raw = 1'b1;
         step();
         if (if0.step_pulse) cnt0++;
         if (if1.step_pulse) cnt1++;
      end
      chk("rep_count0", 32'(cnt0), 32'd1);
      chk("rep_count1", 32'(cnt1), 32'd7);

      // wrap at PC_LAST
      ld  = 1'b1;
      pin = LAST0;
      step();
      ld  = 1'b0;
      wraps = 0;
      raw = 1'b0;
      for (int e = 0; e < 24; e++) begin
         if (e == 12) raw = 1'b1;
         step();
         if (if0.pc_wrap) wraps++;
      end
      chk("wrap_pc",    32'(if0.PC), 32'd0);
      chk("wrap_count", 32'(wraps), 32'd1);

      // load in the same cycle as a step pulse
      found = 0;
      raw = 1'b0;
      for (int e = 0; e < 20 && found == 0; e++) begin
         step();
         if (m_step[0]) found = 1;
      end
      chk("ld_wait", 32'(found), 32'd1);
      ld  = 1'b1;
      pin = 8'h80;
      step();
      ld  = 1'b0;
      chk("ld_wins", 32'(if0.PC), 32'h80);
      raw = 1'b1;
      for (int i = 0; i < 12; i++) step();
      press(12, 12);
      chk("above_last", 32'(if0.PC), 32'h81);

      // hold discards the step
      hold = 1'b1;
      press(12, 12);
      hold = 1'b0;
      chk("hold_pc", 32'(if0.PC), 32'h81);

      // reset during PRESS_B with the button still down
      raw = 1'b0;
      for (int i = 0; i < 4; i++) step();
      pc_clr = 1'b0;
      #1;
      model_reset();
      chk_reset_values("midrst");
      step();
      step();
      pc_clr = 1'b1;
      first_pulse = -1;
      for (int e = 0; e < 20 && first_pulse < 0; e++) begin
         step();
         if (if0.step_pulse) first_pulse = e;
      end
      chk("rst_latency", 32'(first_pulse), 32'(DEB_CYC + 2));
      raw = 1'b1;
      for (int i = 0; i < 12; i++) step();

      // random bursts, loads and holds
      for (seg = 0; seg < 70; seg++) begin
         int len;
         raw = ~raw;
         len = $urandom_range(1, 9);
         for (int i = 0; i < len; i++) begin
            ld   = ($urandom_range(0, 15) == 0);
            pin  = 8'($urandom);
            hold = ($urandom_range(0, 3) == 0);
            step();
         end
      end
      ld   = 1'b0;
      hold = 1'b0;
      raw  = 1'b1;
      for (int i = 0; i < 12; i++) step();
      chk("final_state", 32'(if0.dbg_state), 32'(IDLE));

      // report
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule : tb_pc_step_ctrl
